// File: rtl/jerk_chk_if.sv
// Pattern link between the jerk generator side and the jerk checker.
// Carries the sampled pattern word plus the checker's status outputs.
interface jerk_chk_if;
  logic       in_valid;
  logic [7:0] din;
  logic       locked;
  logic       err;
  logic [3:0] phase;
  logic [7:0] err_count;

  // Generator / stimulus side: drives the pattern, observes status.
  modport master (
    output in_valid,
    output din,
    input  locked,
    input  err,
    input  phase,
    input  err_count
  );

  // Checker side: samples the pattern, reports status.
  modport slave (
    input  in_valid,
    input  din,
    output locked,
    output err,
    output phase,
    output err_count
  );
endinterface

// File: rtl/jerk_chk.sv
// Receive-side checker for the 8-bit jerk walking-bit pattern.
// Hunts for a walking value, confirms alignment over LOCK_CNT samples,
// then flywheels the phase, flags mismatches and drops lock after
// MISS_MAX consecutive misses.
module jerk_chk #(
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 3
) (
  input  logic          clk,
  input  logic          reset,
  jerk_chk_if.slave     bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_CNT);
  localparam logic [3:0] MISS_LIM = 4'(MISS_MAX);

  // Reference pattern word for a given phase (even phases carry 0x80).
  function automatic logic [7:0] seq_val(input logic [3:0] p);
    logic [7:0] v;
    case (p)
      4'd1:    v = 8'h40;
      4'd3:    v = 8'h20;
      4'd5:    v = 8'h10;
      4'd7:    v = 8'h08;
      4'd9:    v = 8'h04;
      4'd11:   v = 8'h02;
      4'd13:   v = 8'h01;
      default: v = 8'h80;
    endcase
    return v;
  endfunction

  // One-hot with the set bit in positions 6..0.
  function automatic logic is_walk(input logic [7:0] d);
    return (d[7] == 1'b0) && (d != 8'd0) && ((d & (d - 8'd1)) == 8'd0);
  endfunction

  // Odd phase that a walking value uniquely identifies.
  function automatic logic [3:0] walk_phase(input logic [7:0] d);
    logic [3:0] p;
    case (d)
      8'h40:   p = 4'd1;
      8'h20:   p = 4'd3;
      8'h10:   p = 4'd5;
      8'h08:   p = 4'd7;
      8'h04:   p = 4'd9;
      8'h02:   p = 4'd11;
      8'h01:   p = 4'd13;
      default: p = 4'd0;
    endcase
    return p;
  endfunction

  state_t     state_r, state_nx_s;
  logic [3:0] good_r,  good_nx_s;
  logic [3:0] miss_r,  miss_nx_s;
  logic [3:0] phase_r, phase_nx_s;
  logic [7:0] cnt_r,   cnt_nx_s;
  logic       err_r,   err_nx_s;
  logic       locked_r, locked_nx_s;
  logic [3:0] phase_inc_s;
  logic       match_s;

  assign phase_inc_s = (phase_r == 4'd13) ? 4'd0 : phase_r + 4'd1;
  assign match_s     = (bus.din == seq_val(phase_inc_s));

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= HUNT;
      good_r   <= 4'd0;
      miss_r   <= 4'd0;
      phase_r  <= 4'd0;
      cnt_r    <= 8'd0;
      err_r    <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      good_r   <= good_nx_s;
      miss_r   <= miss_nx_s;
      phase_r  <= phase_nx_s;
      cnt_r    <= cnt_nx_s;
      err_r    <= err_nx_s;
      locked_r <= locked_nx_s;
    end
  end

  // Next-state and next-output decision for each valid sample.
  always_comb begin
    state_nx_s  = state_r;
    good_nx_s   = good_r;
    miss_nx_s   = miss_r;
    phase_nx_s  = phase_r;
    cnt_nx_s    = cnt_r;
    err_nx_s    = 1'b0;
    locked_nx_s = locked_r;
    if (bus.in_valid) begin
      case (state_r)
        HUNT: begin
          if (is_walk(bus.din)) begin
            phase_nx_s = walk_phase(bus.din);
            good_nx_s  = 4'd1;
            miss_nx_s  = 4'd0;
            if (LOCK_LIM == 4'd1) begin
              state_nx_s  = LOCKED;
              locked_nx_s = 1'b1;
            end else begin
              state_nx_s  = ACQ;
            end
          end else begin
            state_nx_s = HUNT;
          end
        end
        ACQ: begin
          if (match_s) begin
            phase_nx_s = phase_inc_s;
            good_nx_s  = good_r + 4'd1;
            if ((good_r + 4'd1) >= LOCK_LIM) begin
              state_nx_s  = LOCKED;
              locked_nx_s = 1'b1;
              miss_nx_s   = 4'd0;
            end else begin
              state_nx_s  = ACQ;
            end
          end else if (is_walk(bus.din)) begin
            // A different walking value re-seeds rather than aborting.
            phase_nx_s = walk_phase(bus.din);
            good_nx_s  = 4'd1;
          end else begin
            state_nx_s = HUNT;
            good_nx_s  = 4'd0;
          end
        end
        LOCKED: begin
          // Flywheel: phase advances whether or not the sample matches.
          phase_nx_s = phase_inc_s;
          if (match_s) begin
            miss_nx_s = 4'd0;
          end else begin
            err_nx_s  = 1'b1;
            cnt_nx_s  = (cnt_r == 8'hFF) ? 8'hFF : cnt_r + 8'd1;
            miss_nx_s = miss_r + 4'd1;
            if ((miss_r + 4'd1) >= MISS_LIM) begin
              state_nx_s  = HUNT;
              locked_nx_s = 1'b0;
              miss_nx_s   = 4'd0;
              good_nx_s   = 4'd0;
            end else begin
              state_nx_s  = LOCKED;
            end
          end
        end
        default: begin
          state_nx_s  = HUNT;
          locked_nx_s = 1'b0;
          good_nx_s   = 4'd0;
          miss_nx_s   = 4'd0;
        end
      endcase
    end else begin
      err_nx_s = 1'b0;
    end
  end

  assign bus.locked    = locked_r;
  assign bus.err       = err_r;
  assign bus.phase     = phase_r;
  assign bus.err_count = cnt_r;

endmodule

// File: tb/tb_jerk_chk.sv
// Self-checking bench for jerk_chk: directed scenarios followed by a
// randomized stream, all compared against a behavioural reference model.
module tb_jerk_chk;
  localparam int LOCK_CNT = 4;
  localparam int MISS_MAX = 3;

  logic clk;
  logic reset;
  jerk_chk_if bus();

  jerk_chk #(.LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (0 = hunting, 1 = acquiring, 2 = locked).
  int m_state, m_good, m_miss, m_phase, m_cnt;
  int m_err, m_locked;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int seq(input int p);
    if (p % 2 == 0) return 8'h80;
    return 8'h80 >> ((p + 1) / 2);
  endfunction

  function automatic bit walking(input logic [7:0] d);
    return ($countones(d) == 1) && !d[7];
  endfunction

  function automatic int decode(input logic [7:0] d);
    for (int i = 0; i < 7; i++)
      if (d[i]) return 2 * (6 - i) + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_good = 0; m_miss = 0; m_phase = 0;
    m_cnt = 0; m_err = 0; m_locked = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    int nxt;
    m_err = 0;
    if (!v) return;
    nxt = (m_phase + 1) % 14;
    case (m_state)
      0: if (walking(d)) begin
        m_phase = decode(d); m_good = 1; m_miss = 0;
        if (m_good >= LOCK_CNT) begin m_state = 2; m_locked = 1; end
        else m_state = 1;
      end
      1: if (int'(d) == seq(nxt)) begin
        m_phase = nxt; m_good++;
        if (m_good >= LOCK_CNT) begin m_state = 2; m_locked = 1; m_miss = 0; end
      end else if (walking(d)) begin
        m_phase = decode(d); m_good = 1;
      end else begin
        m_state = 0; m_good = 0;
      end
      default: begin
        m_phase = nxt;
        if (int'(d) == seq(nxt)) m_miss = 0;
        else begin
          m_err = 1;
          if (m_cnt < 255) m_cnt++;
          m_miss++;
          if (m_miss >= MISS_MAX) begin
            m_state = 0; m_locked = 0; m_miss = 0; m_good = 0;
          end
        end
      end
    endcase
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".locked"},    int'(bus.locked),    m_locked);
    chk({tag, ".err"},       int'(bus.err),       m_err);
    chk({tag, ".phase"},     int'(bus.phase),     m_phase);
    chk({tag, ".err_count"}, int'(bus.err_count), m_cnt);
  endtask

  // Apply one sample across a rising edge, advance the model, compare.
  task automatic drive(input bit v, input logic [7:0] d, input string tag);
    @(negedge clk);
    bus.in_valid = v;
    bus.din      = d;
    @(posedge clk);
    if (reset) model_step(v, d);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.din = 8'h00;
    model_reset();
    #1;
    compare_all("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [7:0] lock_seq [6];
  int gen_ph;
  int r;
  logic [7:0] d;

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.din = 8'h00;
    model_reset();
    #2;
    do_reset();

    // Lock acquisition.
    lock_seq = '{8'h80, 8'h40, 8'h80, 8'h20, 8'h80, 8'h10};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, lock_seq[i], "acq");
      if (i == 1) chk("seed_phase", int'(bus.phase), 1);
      if (i < 4)  chk("not_locked_yet", int'(bus.locked), 0);
    end
    chk("lock_at4", int'(bus.locked), 1);
    chk("lock_phase", int'(bus.phase), 4);

    // Single corruption while locked.
    drive(1'b1, 8'h00, "corrupt");
    chk("corrupt_err", int'(bus.err), 1);
    chk("corrupt_cnt", int'(bus.err_count), 1);
    chk("corrupt_locked", int'(bus.locked), 1);
    drive(1'b1, 8'h80, "after_corrupt");
    chk("after_corrupt_err", int'(bus.err), 0);
    chk("after_corrupt_phase", int'(bus.phase), 6);

    // Loss of lock after three misses.
    do_reset();
    for (int i = 1; i < 5; i++) drive(1'b1, lock_seq[i], "relock");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h00, "miss");
      chk("miss_err", int'(bus.err), 1);
    end
    chk("miss_cnt", int'(bus.err_count), 3);
    chk("miss_unlock", int'(bus.locked), 0);
    drive(1'b1, 8'h08, "reseed7");
    chk("reseed7_phase", int'(bus.phase), 7);

    // Wrap-around with a valid gap.
    drive(1'b1, 8'h80, "wrap"); drive(1'b1, 8'h04, "wrap");
    drive(1'b1, 8'h80, "wrap"); drive(1'b1, 8'h02, "wrap");
    drive(1'b1, 8'h80, "wrap"); drive(1'b1, 8'h01, "wrap");
    chk("wrap_locked13", int'(bus.locked), 1);
    chk("wrap_phase13", int'(bus.phase), 13);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, "gap");
      chk("gap_phase", int'(bus.phase), 13);
    end
    drive(1'b1, 8'h80, "wrap0");
    chk("wrap0_phase", int'(bus.phase), 0);
    chk("wrap0_err", int'(bus.err), 0);
    drive(1'b1, 8'h40, "wrap1");
    chk("wrap1_phase", int'(bus.phase), 1);

    // Reseed while acquiring, then lock across the wrap.
    do_reset();
    drive(1'b1, 8'h40, "acq_seed");
    drive(1'b1, 8'h02, "acq_reseed");
    chk("reseed_phase", int'(bus.phase), 11);
    chk("reseed_locked", int'(bus.locked), 0);
    chk("reseed_err", int'(bus.err), 0);
    drive(1'b1, 8'h80, "acq2"); drive(1'b1, 8'h01, "acq2");
    drive(1'b1, 8'h80, "acq2");
    chk("wraplock_locked", int'(bus.locked), 1);
    chk("wraplock_phase", int'(bus.phase), 0);

    // Build err_count to 5 while staying locked, then reset mid-cycle.
    for (int i = 0; i < 10; i++) begin
      d = (i % 2 == 0) ? 8'h00 : 8'(seq((m_phase + 1) % 14));
      drive(1'b1, d, "errs");
    end
    chk("pre_rst_cnt", int'(bus.err_count), 5);
    chk("pre_rst_locked", int'(bus.locked), 1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.din = 8'h40;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_locked", int'(bus.locked), 0);
    chk("async_cnt", int'(bus.err_count), 0);
    chk("async_phase", int'(bus.phase), 0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h40, "rst_hold");
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 8'h40, "post_rst");
    chk("post_rst_seed", int'(bus.phase), 1);

    // Randomized stream from a free-running generator with faults.
    gen_ph = 2;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 100) begin
        drive(1'b0, 8'($urandom), "rnd");
      end else begin
        if (r < 800)      d = 8'(seq(gen_ph));
        else if (r < 870) d = 8'h00;
        else if (r < 930) d = 8'($urandom);
        else if (r < 985) d = 8'h01 << $urandom_range(0, 6);
        else begin gen_ph = 0; d = 8'h80; end
        drive(1'b1, d, "rnd");
        gen_ph = (gen_ph + 1) % 14;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
